// File: rtl/cp0_exc_unit.sv
// ============================================================================
// cp0_exc_unit : MIPS-style CP0 exception/interrupt unit with Count/Compare timer
// Revision 1.0
// ============================================================================
`default_nettype none

module cp0_exc_unit #(
    parameter int          N_HWINT     = 6,
    parameter int          COUNT_DIV   = 2,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               commit_valid,
    input  logic [31:0]        commit_pc,
    input  logic               commit_bd,
    input  logic [6:0]         exc_req,
    input  logic [31:0]        badvaddr_in,
    input  logic               eret,
    input  logic               mtc0_wen,
    input  logic [4:0]         cp0_addr,
    input  logic [31:0]        cp0_wdata,
    output logic [31:0]        cp0_rdata,
    input  logic [N_HWINT-1:0] hw_int,
    output logic               flush,
    output logic [31:0]        flush_pc,
    output logic               exl
);

    localparam int         PW             = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [4:0] c_ADDR_BADV    = 5'd8;
    localparam logic [4:0] c_ADDR_COUNT   = 5'd9;
    localparam logic [4:0] c_ADDR_COMPARE = 5'd11;
    localparam logic [4:0] c_ADDR_STATUS  = 5'd12;
    localparam logic [4:0] c_ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] c_ADDR_EPC     = 5'd14;
    localparam logic [1:0] c_BAD_HOLD     = 2'd0;
    localparam logic [1:0] c_BAD_PC       = 2'd1;
    localparam logic [1:0] c_BAD_DATA     = 2'd2;

    logic [SYNC_STAGES-1:0][N_HWINT-1:0] r_sync;
    logic [7:0]  r_im;
    logic [1:0]  r_ip_sw;
    logic        r_exl, r_ie, r_bd, r_ti;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc, r_badv, r_count, r_compare;
    logic [PW-1:0] r_presc;

    logic [5:0]  w_hw6;
    logic [7:0]  w_ip;
    logic        w_int, w_exc, w_eret, w_wen, w_tick, w_count_wr, w_cmp_wr;
    logic [4:0]  w_exc_code;
    logic [1:0]  w_bad_sel;
    logic [31:0] w_count_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= hw_int;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    always_comb begin
        w_hw6 = '0;
        w_hw6[N_HWINT-1:0] = r_sync[SYNC_STAGES-1];
    end

    // The timer interrupt shares IP[7] with the last hardware line.
    assign w_ip  = {w_hw6[5] | r_ti, w_hw6[4:0], r_ip_sw};
    assign w_int = commit_valid & r_ie & ~r_exl & (|(w_ip & r_im));
    assign w_exc = commit_valid & (w_int | (|exc_req));
    assign w_eret = commit_valid & eret & ~w_exc;
    assign w_wen  = commit_valid & mtc0_wen & ~w_exc;

    always_comb begin
        w_exc_code = 5'h00;
        w_bad_sel  = c_BAD_HOLD;
        if (w_int)           w_exc_code = 5'h00;
        else if (exc_req[0]) begin w_exc_code = 5'h04; w_bad_sel = c_BAD_PC;   end
        else if (exc_req[1]) w_exc_code = 5'h0A;
        else if (exc_req[2]) w_exc_code = 5'h0C;
        else if (exc_req[3]) w_exc_code = 5'h08;
        else if (exc_req[4]) w_exc_code = 5'h09;
        else if (exc_req[5]) begin w_exc_code = 5'h04; w_bad_sel = c_BAD_DATA; end
        else if (exc_req[6]) begin w_exc_code = 5'h05; w_bad_sel = c_BAD_DATA; end
    end

    assign flush    = ~reset & (w_exc | w_eret);
    assign flush_pc = w_exc ? EXC_VECTOR : r_epc;
    assign exl      = r_exl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exl <= 1'b0; r_ie <= 1'b0; r_im <= '0; r_ip_sw <= '0;
            r_bd <= 1'b0; r_exc_code <= '0; r_epc <= '0; r_badv <= '0;
        end else begin
            if (w_exc) begin
                r_exc_code <= w_exc_code;
                r_exl      <= 1'b1;
                // A nested exception keeps the original return context.
                if (!r_exl) begin
                    r_epc <= commit_bd ? commit_pc - 32'd4 : commit_pc;
                    r_bd  <= commit_bd;
                end
                case (w_bad_sel)
                    c_BAD_PC:   r_badv <= commit_pc;
                    c_BAD_DATA: r_badv <= badvaddr_in;
                    default:    ;
                endcase
            end else if (w_eret) begin
                r_exl <= 1'b0;
            end
            if (w_wen) begin
                case (cp0_addr)
                    c_ADDR_STATUS: begin
                        r_im  <= cp0_wdata[15:8];
                        r_exl <= cp0_wdata[1];
                        r_ie  <= cp0_wdata[0];
                    end
                    c_ADDR_CAUSE: r_ip_sw <= cp0_wdata[9:8];
                    c_ADDR_EPC:   r_epc   <= cp0_wdata;
                    default:      ;
                endcase
            end
        end
    end

    assign w_count_wr  = w_wen && (cp0_addr == c_ADDR_COUNT);
    assign w_cmp_wr    = w_wen && (cp0_addr == c_ADDR_COMPARE);
    assign w_tick      = (COUNT_DIV == 1) || (&r_presc);
    assign w_count_nxt = w_count_wr ? cp0_wdata : (w_tick ? r_count + 32'd1 : r_count);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0; r_count <= '0; r_compare <= '0; r_ti <= 1'b0;
        end else begin
            if (w_count_wr)         r_presc <= '0;
            else if (COUNT_DIV > 1) r_presc <= r_presc + PW'(1);
            r_count <= w_count_nxt;
            if (w_cmp_wr) r_compare <= cp0_wdata;
            if (w_cmp_wr)
                r_ti <= 1'b0;
            else if ((w_count_nxt == r_compare) && (r_count != r_compare))
                r_ti <= 1'b1;
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            c_ADDR_BADV:    cp0_rdata = r_badv;
            c_ADDR_COUNT:   cp0_rdata = r_count;
            c_ADDR_COMPARE: cp0_rdata = r_compare;
            c_ADDR_STATUS:  cp0_rdata = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
            c_ADDR_CAUSE:   cp0_rdata = {r_bd, r_ti, 14'b0, w_ip, 1'b0, r_exc_code, 2'b0};
            c_ADDR_EPC:     cp0_rdata = r_epc;
            default:        cp0_rdata = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: doc/cp0_exc_unit.md
CP0_EXC_UNIT -- requirements
Module: cp0_exc_unit

Interface
REQ-001 SHALL have parameter N_HWINT, default 6, meaning the number of hardware interrupt lines (legal range 1..6).
REQ-002 SHALL have parameter COUNT_DIV, default 2, meaning clk cycles per Count increment (power of 2, legal range 1..16).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning the flop depth of the hw_int synchronizer (legal range 1..3).
REQ-004 SHALL have parameter EXC_VECTOR, default 32'hBFC00380, meaning the general exception entry PC.
REQ-005 SHALL have these ports (clock and reset first); one clock; reset is asynchronous and active-high.
  clk  in  1  sole clock, rising edge.
  reset  in  1  asynchronous, active-high.
  commit_valid  in  1  MEM-stage instruction is committing this cycle.
  commit_pc  in  32  PC of the committing instruction.
  commit_bd  in  1  committing instruction sits in a delay slot.
  exc_req  in  7  {AdES, AdEL_d, Bp, Sys, OV, RI, AdEL_if} flags of the committing instruction.
  badvaddr_in  in  32  faulting address for AdEL/AdES.
  eret  in  1  committing instruction is ERET.
  mtc0_wen  in  1  committing instruction is MTC0.
  cp0_addr  in  5  CP0 register number for MTC0/MFC0.
  cp0_wdata  in  32  MTC0 data.
  cp0_rdata  out  32  MFC0 data, combinational.
  hw_int  in  N_HWINT  asynchronous hardware interrupt lines.
  flush  out  1  pipeline flush, combinational.
  flush_pc  out  32  redirect PC, valid when flush=1.
  exl  out  1  Status.EXL.

Function
REQ-006 SHALL pass hw_int through SYNC_STAGES flops. IP[2+i] = synced hw_int[i]. Unused IP[7:2] bits read 0. IP[7] additionally ORs TI.
REQ-007 SHALL take an interrupt when commit_valid & IE & !EXL & |(IP[7:0] & IM[7:0]).
REQ-008 SHALL resolve a single event per cycle. Priority: interrupt > AdEL_if > RI > OV > Sys > Bp > AdEL_d > AdES. ExcCode values: 0x00, 0x04, 0x0A, 0x0C, 0x08, 0x09, 0x04, 0x05.
REQ-009 On any exception, the same cycle SHALL drive flush=1 and flush_pc=EXC_VECTOR.
REQ-010 At the next edge after an exception, Cause.ExcCode SHALL be registered and EXL set to 1.
REQ-011 Only if EXL was 0 at an exception SHALL EPC be loaded with commit_bd ? commit_pc-4 : commit_pc, and Cause.BD with commit_bd. Otherwise both SHALL be held.
REQ-012 SHALL load BadVAddr with commit_pc for AdEL_if. It SHALL load BadVAddr with badvaddr_in for AdEL_d/AdES, and hold it otherwise.
REQ-013 ERET with commit_valid and no exception SHALL drive flush=1 and flush_pc=EPC, then clear EXL at the next edge.
REQ-014 If an exception and ERET coincide, the exception SHALL win and EXL SHALL stay 1.
REQ-015 MTC0 SHALL write at the edge only when commit_valid and no exception. Exception suppresses the write.
REQ-016 Writable fields SHALL be:
  Status: IM[15:8], EXL[1], IE[0]; BEV[22] reads 1.
  Cause: IP[9:8].
  EPC, Count, Compare: full 32 bits.
  BadVAddr: read-only.
REQ-017 SHALL decode register numbers as BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14. Any other cp0_addr reads 0 and ignores writes.
REQ-018 Cause SHALL read {BD, TI, 14'b0, IP[7:0], 1'b0, ExcCode, 2'b0}.
REQ-019 Count SHALL increment by 1 on every COUNT_DIV-th clk via a log2(COUNT_DIV)-bit prescaler, wrapping 32'hFFFFFFFF->0. A Count write SHALL load cp0_wdata and clear the prescaler.
REQ-020 TI SHALL set at the edge where Count becomes equal to Compare. A Compare write SHALL clear TI; if both occur in the same cycle, the clear wins.
REQ-021 cp0_rdata SHALL reflect register state before the current edge; there is no write-to-read bypass.
REQ-022 With commit_valid=0, no interrupt, exception, ERET or MTC0 SHALL take effect, and flush SHALL be 0.

Reset
REQ-023 Assertion of reset SHALL immediately (asynchronously) clear EXL, IE, IM, IP[1:0], TI, BD, ExcCode, EPC, BadVAddr, Count, Compare, the prescaler and the sync flops.
REQ-024 During reset, flush=0 and exl=0.
REQ-025 Reset mid-operation SHALL abandon any pending event. The first post-reset commit SHALL see cleared state.

Verification
REQ-026 Status=0x0000_8001 written, hw_int[5]=1 with commit_valid -> flush=1 after SYNC_STAGES+1 cycles, flush_pc=0xBFC00380, ExcCode=0, EPC=commit_pc, exl=1.
REQ-027 OV and Sys together, commit_bd=1, commit_pc=0x8000_0104 -> ExcCode=0x0C, EPC=0x8000_0100, Cause[31]=1.
REQ-028 Second exception while EXL=1 (RI) -> ExcCode=0x0A, EPC unchanged, flush_pc=0xBFC00380; then ERET -> flush_pc=EPC, exl=0.
REQ-029 COUNT_DIV=2, Compare=5 written at Count=0 -> TI=1 after ~10 cycles, Cause[30]=1; Compare rewrite -> TI=0.
REQ-030 MTC0 EPC with AdES in the same cycle -> EPC not written from cp0_wdata, BadVAddr=badvaddr_in, ExcCode=0x05.
REQ-031 Reset asserted mid-ERET -> flush drops immediately, all registers 0, cp0_rdata(Status)=0x0040_0000.
